float32_to_int_conv: RTL and testbench

- Parametrised successor of the fixed float32→uint32 converter for the SinWaveGenerator datapath.
- Converts IEEE-754 single-precision to a signed or unsigned integer of configurable width, with run-time rounding mode.
- Adds valid/ready flow control with back-pressure, plus per-sample status flags.
- Sits between the float sine core and the DAC/PWM integer consumers.

---
 rtl/f2i_pkg.sv | 49 ++++
 rtl/f2i_round_shift.sv | 77 +++++++
 rtl/float32_to_int_conv.sv | 210 +++++++++++++++++++++
 tb/tb_float32_to_int_conv.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f2i_pkg.sv
// Shared constants, types and helpers for the float32 -> integer converter.
package f2i_pkg;

    // Rounding mode encodings carried alongside each sample.
    localparam logic [1:0] RND_TRUNC = 2'b00;
    localparam logic [1:0] RND_HAWAY = 2'b01;
    localparam logic [1:0] RND_RNE   = 2'b10;

    // IEEE-754 single-precision field constants.
    localparam int         FP_BIAS    = 127;
    localparam int         FP_MANT_W  = 23;
    localparam int         FP_EXP_W   = 8;
    localparam logic [7:0] FP_EXP_MAX = 8'hFF;

    // Width of the unbiased exponent (exp - bias spans -127..128).
    localparam int EXP_UNB_W = 10;

    // Input classification. Denormals fold into CLS_ZERO: they always produce 0.
    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } cls_e;

    // Unpacked sample as held between S1 and S2.
    typedef struct packed {
        logic                 sign;
        logic [EXP_UNB_W-1:0] e;
        logic [FP_MANT_W-1:0] mant;
        cls_e                 cls;
        logic [1:0]           rnd;
    } s1_t;

    // Classify a float from its raw exponent and mantissa fields.
    function automatic cls_e classify(input logic [FP_EXP_W-1:0]  exp_f,
                                      input logic [FP_MANT_W-1:0] mant_f);
        cls_e c;
        if (exp_f == '0) begin
            c = CLS_ZERO;
        end else if (exp_f == FP_EXP_MAX) begin
            c = (mant_f == '0) ? CLS_INF : CLS_NAN;
        end else begin
            c = CLS_NORM;
        end
        return c;
    endfunction

endpackage

// File: rtl/f2i_round_shift.sv
// S2 combinational aligner and rounder for the float32 -> integer converter.
// Produces the rounded magnitude in an (OUT_WIDTH+1)-bit field so that a
// rounding carry past 2^OUT_WIDTH-1 remains visible to the saturation stage.
// Optional macro F2I_RNE_EN: when defined, mode 2'b10 rounds to nearest with
// ties to even; otherwise mode 2'b10 behaves as round half away from zero.
module f2i_round_shift
    import f2i_pkg::*;
#(
    parameter int OUT_WIDTH = 32
) (
    input  logic [FP_MANT_W:0]          sig_i,       // {hidden bit, mantissa}
    input  logic signed [EXP_UNB_W-1:0] e_i,         // unbiased exponent
    input  logic [1:0]                  rnd_i,
    output logic [OUT_WIDTH:0]          mag_o,
    output logic                        inexact_o,
    output logic                        ovf_pend_o
);

    // Fixed-point field: OUT_WIDTH+1 integer bits above a 24-bit fraction.
    // Placing sig at shift E+1 makes bit 23 the guard (weight 1/2).
    localparam int FIELD_W = OUT_WIDTH + FP_MANT_W + 2;

    logic               tiny;
    logic               ovf_pend;
    logic [6:0]         sh;
    logic [FIELD_W-1:0] field;
    logic [OUT_WIDTH:0] int_part;
    logic               guard;
    logic               sticky;
    logic               inc;

    // |x| < 0.5: every significand bit lies below the guard position.
    assign tiny     = (e_i < -10'sd1);
    // |x| >= 2^OUT_WIDTH never fits, whatever the signedness.
    assign ovf_pend = (e_i >= $signed(EXP_UNB_W'(OUT_WIDTH)));
    // Only meaningful when -1 <= E < OUT_WIDTH, i.e. 0..OUT_WIDTH.
    assign sh       = 7'(e_i + 10'sd1);

    // Align the significand into the fixed-point field.
    always_comb begin
        // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
        field = '0;
        if (!tiny && !ovf_pend) begin
            field = {{(OUT_WIDTH + 1){1'b0}}, sig_i} << sh;
        end
    end

    assign int_part = field[FIELD_W-1:FP_MANT_W+1];
    assign guard    = field[FP_MANT_W];
    assign sticky   = (|field[FP_MANT_W-1:0]) | tiny;

`ifdef F2I_RNE_EN
    // Round-up decision, including ties-to-even for mode 2'b10.
    always_comb begin
        inc = 1'b0;
        case (rnd_i)
            RND_TRUNC: inc = 1'b0;
            RND_RNE:   inc = guard & (sticky | int_part[0]);
            default:   inc = guard;
        endcase
    end
`else
    // Round-up decision: every non-truncating mode rounds half away from zero.
    always_comb begin
        inc = 1'b0;
        if (rnd_i != RND_TRUNC) begin
            inc = guard;
        end
    end
`endif

    // int_part < 2^OUT_WIDTH here, so the increment cannot wrap the field.
    assign mag_o      = int_part + {{OUT_WIDTH{1'b0}}, inc};
    assign inexact_o  = guard | sticky;
    assign ovf_pend_o = ovf_pend;

endmodule

// File: rtl/float32_to_int_conv.sv
// IEEE-754 single-precision to signed/unsigned integer converter with a
// 3-stage valid/ready pipeline: S1 unpack, S2 align/round, S3 sign/saturate.
// A single advance enable moves all stages together; when the output is
// stalled every stage holds, so results and flags stay stable.
// Optional macro F2I_RNE_EN enables round-to-nearest-even for mode 2'b10.
module float32_to_int_conv
    import f2i_pkg::*;
#(
    parameter int OUT_WIDTH  = 32,   // 8..64
    parameter int SIGNED_OUT = 0     // 0: unsigned, 1: two's complement
) (
    input  logic                 aclk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [31:0]          s_data,
    input  logic [1:0]           s_rnd_mode,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [OUT_WIDTH-1:0] m_data,
    output logic                 m_ovf,
    output logic                 m_nan,
    output logic                 m_inexact
);

    // Saturation limits, expressed as W-bit results and (W+1)-bit magnitudes.
    localparam logic [OUT_WIDTH-1:0] UMAX     = '1;
    localparam logic [OUT_WIDTH-1:0] SMAX     = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SMIN     = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
    localparam logic [OUT_WIDTH:0]   SMAX_MAG = {2'b00, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH:0]   SMIN_MAG = {2'b01, {(OUT_WIDTH - 1){1'b0}}};

    logic en;

    // S1 state
    s1_t  s1_d, s1_q;
    logic s1_valid_q;

    // S2 state
    logic               s2_valid_q;
    logic               s2_sign_d, s2_sign_q;
    cls_e               s2_cls_d, s2_cls_q;
    logic [OUT_WIDTH:0] s2_mag_d, s2_mag_q;
    logic               s2_ovf_pend_d, s2_ovf_pend_q;
    logic               s2_inexact_d, s2_inexact_q;

    // S3 state (drives the outputs directly)
    logic                 s3_valid_q;
    logic [OUT_WIDTH-1:0] s3_data_d, s3_data_q;
    logic                 s3_ovf_d, s3_ovf_q;
    logic                 s3_nan_d, s3_nan_q;
    logic                 s3_inexact_d, s3_inexact_q;

    // Round/shift results
    logic [OUT_WIDTH:0] rs_mag;
    logic               rs_inexact;
    logic               rs_ovf_pend;

    // Whole pipeline advances unless a valid result is waiting on downstream.
    assign en      = !s3_valid_q || m_ready;
    assign s_ready = en;

    // ---------------------------------------------------------------- S1
    // Unpack the float and classify it; the rounding mode travels with it.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = s_data[31];
        s1_d.e    = {2'b00, s_data[30:23]} - EXP_UNB_W'(FP_BIAS);
        s1_d.mant = s_data[FP_MANT_W-1:0];
        s1_d.cls  = classify(s_data[30:23], s_data[FP_MANT_W-1:0]);
        s1_d.rnd  = s_rnd_mode;
    end

    // S1 register: captures a sample on every advance (bubble if !s_valid).
    always_ff @(posedge aclk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (en) begin
            s1_valid_q <= s_valid;
            s1_q       <= s1_d;
        end
    end

    // ---------------------------------------------------------------- S2
    f2i_round_shift #(
        .OUT_WIDTH (OUT_WIDTH)
    ) u_round_shift (
        .sig_i      ({1'b1, s1_q.mant}),
        .e_i        ($signed(s1_q.e)),
        .rnd_i      (s1_q.rnd),
        .mag_o      (rs_mag),
        .inexact_o  (rs_inexact),
        .ovf_pend_o (rs_ovf_pend)
    );

    // Select the rounded magnitude only for normals; zero/denormal, Inf and NaN bypass.
    always_comb begin
        s2_sign_d     = s1_q.sign;
        s2_cls_d      = s1_q.cls;
        s2_mag_d      = '0;
        s2_ovf_pend_d = 1'b0;
        s2_inexact_d  = 1'b0;
        case (s1_q.cls)
            CLS_NORM: begin
                s2_mag_d      = rs_mag;
                s2_ovf_pend_d = rs_ovf_pend;
                s2_inexact_d  = rs_inexact;
            end
            CLS_ZERO: s2_inexact_d = |s1_q.mant;   // denormal: all bits discarded
            default:  ;
        endcase
    end

    // S2 register.
    always_ff @(posedge aclk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so no X can reach the outputs after a mid-stream reset.
        if (!rst_n) begin
            s2_valid_q    <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_cls_q      <= CLS_ZERO;
            s2_mag_q      <= '0;
            s2_ovf_pend_q <= 1'b0;
            s2_inexact_q  <= 1'b0;
        end else if (en) begin
            s2_valid_q    <= s1_valid_q;
            s2_sign_q     <= s2_sign_d;
            s2_cls_q      <= s2_cls_d;
            s2_mag_q      <= s2_mag_d;
            s2_ovf_pend_q <= s2_ovf_pend_d;
            s2_inexact_q  <= s2_inexact_d;
        end
    end

    // ---------------------------------------------------------------- S3
    // Apply sign and saturate to the output range; any clamp is also inexact.
    always_comb begin
        s3_data_d = '0;
        s3_ovf_d  = 1'b0;
        s3_nan_d  = 1'b0;
        case (s2_cls_q)
            CLS_NAN: s3_nan_d = 1'b1;
            CLS_INF: begin
                s3_ovf_d = 1'b1;
                if (SIGNED_OUT != 0) begin
                    s3_data_d = s2_sign_q ? SMIN : SMAX;
                end else begin
                    s3_data_d = s2_sign_q ? '0 : UMAX;
                end
            end
            CLS_NORM: begin
                if (SIGNED_OUT != 0) begin
                    if (!s2_sign_q) begin
                        if (s2_ovf_pend_q || (s2_mag_q > SMAX_MAG)) begin
                            s3_data_d = SMAX;
                            s3_ovf_d  = 1'b1;
                        end else begin
                            s3_data_d = s2_mag_q[OUT_WIDTH-1:0];
                        end
                    end else begin
                        if (s2_ovf_pend_q || (s2_mag_q > SMIN_MAG)) begin
                            s3_data_d = SMIN;
                            s3_ovf_d  = 1'b1;
                        end else begin
                            s3_data_d = '0 - s2_mag_q[OUT_WIDTH-1:0];
                        end
                    end
                end else begin
                    if (s2_sign_q) begin
                        // Negative values clamp to 0; only a nonzero magnitude is an overflow.
                        s3_ovf_d = s2_ovf_pend_q || (s2_mag_q != '0);
                    end else if (s2_ovf_pend_q || s2_mag_q[OUT_WIDTH]) begin
                        s3_data_d = UMAX;
                        s3_ovf_d  = 1'b1;
                    end else begin
                        s3_data_d = s2_mag_q[OUT_WIDTH-1:0];
                    end
                end
            end
            default: ;   // CLS_ZERO: result 0, inexact carried from S2
        endcase
        // NaN reports only m_nan; everything else is inexact if bits were dropped or clamped.
        s3_inexact_d = (s2_cls_q != CLS_NAN) && (s2_inexact_q || s3_ovf_d);
    end

    // S3 register: holds the presented result while downstream stalls.
    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            s3_valid_q   <= 1'b0;
            s3_data_q    <= '0;
            s3_ovf_q     <= 1'b0;
            s3_nan_q     <= 1'b0;
            s3_inexact_q <= 1'b0;
        end else if (en) begin
            s3_valid_q   <= s2_valid_q;
            s3_data_q    <= s3_data_d;
            s3_ovf_q     <= s3_ovf_d;
            s3_nan_q     <= s3_nan_d;
            s3_inexact_q <= s3_inexact_d;
        end
    end

    assign m_valid   = s3_valid_q;
    assign m_data    = s3_data_q;
    assign m_ovf     = s3_ovf_q;
    assign m_nan     = s3_nan_q;
    assign m_inexact = s3_inexact_q;

endmodule

// File: tb/tb_float32_to_int_conv.sv
// Self-checking bench for float32_to_int_conv. Five configurations run in
// lock-step on shared inputs: u32, s16, s8, s32, u64. A behavioural model
// (exact integer arithmetic on the float value) checks every delivered result.
module tb_float32_to_int_conv;

    localparam int NI = 5;

    logic        aclk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [31:0] s_data;
    logic [1:0]  s_rnd_mode;
    logic        m_ready;

    logic [NI-1:0] s_ready_v, m_valid_v, ovf_v, nan_v, inx_v;
    logic [31:0]   d0;
    logic [15:0]   d1;
    logic [7:0]    d2;
    logic [31:0]   d3;
    logic [63:0]   d4;
    logic [63:0]   data_v [NI];

    int checks    = 0;
    int failures  = 0;
    int delivered = 0;

    typedef struct {
        logic [31:0] f;
        logic [1:0]  mode;
    } smp_t;

    typedef struct {
        logic [63:0] data;
        bit          ovf;
        bit          nan;
        bit          inx;
    } res_t;

    smp_t exp_q[$];

    always #5 aclk = ~aclk;

    float32_to_int_conv #(.OUT_WIDTH(32), .SIGNED_OUT(0)) u_u32 (
        .aclk(aclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_v[0]),
        .s_data(s_data), .s_rnd_mode(s_rnd_mode), .m_valid(m_valid_v[0]), .m_ready(m_ready),
        .m_data(d0), .m_ovf(ovf_v[0]), .m_nan(nan_v[0]), .m_inexact(inx_v[0]));
    float32_to_int_conv #(.OUT_WIDTH(16), .SIGNED_OUT(1)) u_s16 (
        .aclk(aclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_v[1]),
        .s_data(s_data), .s_rnd_mode(s_rnd_mode), .m_valid(m_valid_v[1]), .m_ready(m_ready),
        .m_data(d1), .m_ovf(ovf_v[1]), .m_nan(nan_v[1]), .m_inexact(inx_v[1]));
    float32_to_int_conv #(.OUT_WIDTH(8), .SIGNED_OUT(1)) u_s8 (
        .aclk(aclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_v[2]),
        .s_data(s_data), .s_rnd_mode(s_rnd_mode), .m_valid(m_valid_v[2]), .m_ready(m_ready),
        .m_data(d2), .m_ovf(ovf_v[2]), .m_nan(nan_v[2]), .m_inexact(inx_v[2]));
    float32_to_int_conv #(.OUT_WIDTH(32), .SIGNED_OUT(1)) u_s32 (
        .aclk(aclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_v[3]),
        .s_data(s_data), .s_rnd_mode(s_rnd_mode), .m_valid(m_valid_v[3]), .m_ready(m_ready),
        .m_data(d3), .m_ovf(ovf_v[3]), .m_nan(nan_v[3]), .m_inexact(inx_v[3]));
    float32_to_int_conv #(.OUT_WIDTH(64), .SIGNED_OUT(0)) u_u64 (
        .aclk(aclk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_v[4]),
        .s_data(s_data), .s_rnd_mode(s_rnd_mode), .m_valid(m_valid_v[4]), .m_ready(m_ready),
        .m_data(d4), .m_ovf(ovf_v[4]), .m_nan(nan_v[4]), .m_inexact(inx_v[4]));

    assign data_v[0] = {32'd0, d0};
    assign data_v[1] = {48'd0, d1};
    assign data_v[2] = {56'd0, d2};
    assign data_v[3] = {32'd0, d3};
    assign data_v[4] = d4;

    function automatic int w_of(input int i);
        case (i)
            0: return 32;
            1: return 16;
            2: return 8;
            3: return 32;
            default: return 64;
        endcase
    endfunction

    function automatic bit sg_of(input int i);
        return (i == 1) || (i == 2) || (i == 3);
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference: exact value sig * 2^(E-23), rounded by comparing the
    // discarded fraction with one half, then clamped to the output range.
    function automatic res_t model(input int w, input bit sgn, input logic [31:0] f,
                                   input logic [1:0] mode);
        res_t         r;
        logic [127:0] sig, ip, frac, half, mag, mask, umax, smax, sminm;
        int           e, sh;
        bit           up;
        r     = '{data: 64'd0, ovf: 1'b0, nan: 1'b0, inx: 1'b0};
        mask  = (128'd1 << w) - 128'd1;
        umax  = mask;
        smax  = (128'd1 << (w - 1)) - 128'd1;
        sminm = 128'd1 << (w - 1);
        if (f[30:23] == 8'hFF && f[22:0] != 23'd0) begin
            r.nan = 1'b1;
            return r;
        end
        if (f[30:23] == 8'hFF) begin
            r.ovf = 1'b1;
            r.inx = 1'b1;
            if (!f[31]) r.data = 64'(sgn ? smax : umax);
            else        r.data = 64'(sgn ? sminm : 128'd0);
            return r;
        end
        if (f[30:23] == 8'h00) begin
            r.inx = (f[22:0] != 23'd0);
            return r;
        end
        e   = int'(f[30:23]) - 127;
        sig = {104'd0, 1'b1, f[22:0]};
        if (e >= 23) begin
            ip = sig << (e - 23); frac = 128'd0; half = 128'd1;
        end else if (e >= -1) begin
            sh   = 23 - e;
            ip   = sig >> sh;
            frac = sig & ((128'd1 << sh) - 128'd1);
            half = 128'd1 << (sh - 1);
        end else begin
            ip = 128'd0; frac = 128'd1; half = 128'd2;   // nonzero, below one half
        end
        case (mode)
            2'b00: up = 1'b0;
`ifdef F2I_RNE_EN
            2'b10: up = (frac > half) || (frac == half && ip[0]);
`endif
            default: up = (frac >= half);
        endcase
        mag   = ip + {127'd0, up};
        r.inx = (frac != 128'd0);
        if (!sgn) begin
            if (f[31]) begin
                r.data = 64'd0; r.ovf = (mag != 128'd0);
            end else if (mag > umax) begin
                r.data = 64'(umax); r.ovf = 1'b1;
            end else begin
                r.data = 64'(mag);
            end
        end else begin
            if (!f[31]) begin
                if (mag > smax) begin r.data = 64'(smax); r.ovf = 1'b1; end
                else r.data = 64'(mag);
            end else begin
                if (mag > sminm) begin r.data = 64'(sminm); r.ovf = 1'b1; end
                else r.data = 64'((~mag + 128'd1) & mask);
            end
        end
        if (r.ovf) r.inx = 1'b1;
        return r;
    endfunction

    // Scoreboard: record accepted samples and check every presented result.
    always @(negedge aclk) begin
        res_t r;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (m_valid_v[0]) begin
                if (exp_q.size() == 0) begin
                    check("spurious_m_valid", 64'(m_valid_v[0]), 64'd0);
                end else begin
                    for (int i = 0; i < NI; i++) begin
                        r = model(w_of(i), sg_of(i), exp_q[0].f, exp_q[0].mode);
                        if (i != 0) check($sformatf("valid_i%0d", i), 64'(m_valid_v[i]), 64'd1);
                        check($sformatf("data_i%0d_f%08h_m%0d", i, exp_q[0].f, exp_q[0].mode),
                              data_v[i], r.data);
                        check($sformatf("ovf_i%0d_f%08h", i, exp_q[0].f), 64'(ovf_v[i]), 64'(r.ovf));
                        check($sformatf("nan_i%0d_f%08h", i, exp_q[0].f), 64'(nan_v[i]), 64'(r.nan));
                        check($sformatf("inx_i%0d_f%08h_m%0d", i, exp_q[0].f, exp_q[0].mode),
                              64'(inx_v[i]), 64'(r.inx));
                    end
                    if (m_ready) begin
                        void'(exp_q.pop_front());
                        delivered++;
                    end
                end
            end
            if (s_valid && s_ready_v[0]) exp_q.push_back('{f: s_data, mode: s_rnd_mode});
        end
    end

    // Present one sample and hold it until accepted; returns just after the accepting edge.
    task automatic send(input logic [31:0] f, input logic [1:0] m);
        int n = 0;
        s_valid    = 1'b1;
        s_data     = f;
        s_rnd_mode = m;
        forever begin
            @(negedge aclk);
            if (s_ready_v[0]) break;
            n++;
            if (n > 50) begin
                check("send_timeout", 64'd1, 64'd0);
                break;
            end
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic idle(input int n);
        s_valid = 1'b0;
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // One sample with hand-computed expectations on one configuration.
    task automatic lit(input string nm, input int inst, input logic [31:0] f, input logic [1:0] m,
                       input logic [63:0] ed, input bit eo, input bit enan, input bit ei);
        int   n = 0;
        res_t r;
        r = model(w_of(inst), sg_of(inst), f, m);
        check({nm, "_model"}, r.data, ed);
        send(f, m);
        s_valid = 1'b0;
        while (!m_valid_v[inst] && n < 20) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check({nm, "_valid"}, 64'(m_valid_v[inst]), 64'd1);
        check({nm, "_data"}, data_v[inst], ed);
        check({nm, "_ovf"}, 64'(ovf_v[inst]), 64'(eo));
        check({nm, "_nan"}, 64'(nan_v[inst]), 64'(enan));
        check({nm, "_inexact"}, 64'(inx_v[inst]), 64'(ei));
        idle(1);
    endtask

    logic [31:0] sweep [14] = '{
        32'h3FC00000, 32'h40200000, 32'hC0200000, 32'h4F000000, 32'hCF000000,
        32'h477FFF80, 32'h501502F9, 32'h3F7FFFFF, 32'hBF000000, 32'h437F8000,
        32'h7FA00000, 32'h80000001, 32'h5F800000, 32'hDF000000};
    logic [31:0] flow [6] = '{
        32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d_before;
        logic [63:0] held;

        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_rnd_mode = 2'b00; m_ready = 1'b1;
        #3;
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst_m_valid_i%0d", i), 64'(m_valid_v[i]), 64'd0);
            check($sformatf("rst_m_data_i%0d", i), data_v[i], 64'd0);
            check($sformatf("rst_flags_i%0d", i), 64'({ovf_v[i], nan_v[i], inx_v[i]}), 64'd0);
        end
        repeat (2) @(negedge aclk);
        rst_n = 1'b1;
        @(posedge aclk);
        #1;
        check("rst_s_ready", 64'(s_ready_v), 64'h1F);

        // Latency: the accepting edge is clock 1; m_valid follows the third edge.
        send(32'h40490FDB, 2'b01);
        s_valid = 1'b0;
        check("lat_clk1_m_valid", 64'(m_valid_v[0]), 64'd0);
        @(posedge aclk); #1;
        check("lat_clk2_m_valid", 64'(m_valid_v[0]), 64'd0);
        @(posedge aclk); #1;
        check("lat_clk3_m_valid", 64'(m_valid_v[0]), 64'd1);
        check("lat_pi_data", data_v[0], 64'd3);
        idle(2);

        lit("pi_h",      0, 32'h40490FDB, 2'b01, 64'd3, 1'b0, 1'b0, 1'b1);
        lit("p2_5_trunc",0, 32'h40200000, 2'b00, 64'd2, 1'b0, 1'b0, 1'b1);
        lit("p2_5_haway",0, 32'h40200000, 2'b01, 64'd3, 1'b0, 1'b0, 1'b1);
`ifdef F2I_RNE_EN
        lit("p2_5_rne",  0, 32'h40200000, 2'b10, 64'd2, 1'b0, 1'b0, 1'b1);
        lit("p0_5_rne",  0, 32'h3F000000, 2'b10, 64'd0, 1'b0, 1'b0, 1'b1);
`else
        lit("p2_5_m10",  0, 32'h40200000, 2'b10, 64'd3, 1'b0, 1'b0, 1'b1);
        lit("p0_5_m10",  0, 32'h3F000000, 2'b10, 64'd1, 1'b0, 1'b0, 1'b1);
`endif
        lit("p3_5_m10",  0, 32'h40600000, 2'b10, 64'd4, 1'b0, 1'b0, 1'b1);
        lit("p2_5_m11",  0, 32'h40200000, 2'b11, 64'd3, 1'b0, 1'b0, 1'b1);
        lit("m1_u32",    0, 32'hBF800000, 2'b00, 64'd0, 1'b1, 1'b0, 1'b1);
        lit("m1_s16",    1, 32'hBF800000, 2'b00, 64'hFFFF, 1'b0, 1'b0, 1'b0);
        lit("m0_3_u32",  0, 32'hBE99999A, 2'b01, 64'd0, 1'b0, 1'b0, 1'b1);
        lit("p2e32_u32", 0, 32'h4F800000, 2'b01, 64'hFFFFFFFF, 1'b1, 1'b0, 1'b1);
        lit("p127_6_s8", 2, 32'h42FF3333, 2'b01, 64'h7F, 1'b1, 1'b0, 1'b1);
        lit("m128_s8",   2, 32'hC3000000, 2'b01, 64'h80, 1'b0, 1'b0, 1'b0);
        lit("qnan_u32",  0, 32'h7FC00000, 2'b01, 64'd0, 1'b0, 1'b1, 1'b0);
        lit("minf_s32",  3, 32'hFF800000, 2'b01, 64'h80000000, 1'b1, 1'b0, 1'b1);
        lit("pinf_u64",  4, 32'h7F800000, 2'b00, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 1'b1);
        lit("p2e63_u64", 4, 32'h5F000000, 2'b00, 64'h8000000000000000, 1'b0, 1'b0, 1'b0);
        lit("denorm_u32",0, 32'h00000001, 2'b01, 64'd0, 1'b0, 1'b0, 1'b1);
        lit("mzero_s32", 3, 32'h80000000, 2'b01, 64'd0, 1'b0, 1'b0, 1'b0);

        // Back-to-back sweep over all modes; the mode changes per sample.
        foreach (sweep[v]) begin
            for (int m = 0; m < 4; m++) send(sweep[v], 2'(m));
        end
        idle(1);
        wait_drain();

        // Flow control: 6 samples, output stalled for 5 clocks mid-stream.
        d_before = delivered;
        fork
            begin
                foreach (flow[k]) send(flow[k], 2'b01);
                s_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge aclk);
                #1;
                m_ready = 1'b0;
                @(negedge aclk);
                check("stall_s_ready", 64'(s_ready_v), 64'd0);
                held = data_v[0];
                repeat (5) @(posedge aclk);
                #1;
                check("stall_data_stable", data_v[0], held);
                check("stall_m_valid_held", 64'(m_valid_v[0]), 64'd1);
                m_ready = 1'b1;
            end
        join
        wait_drain();
        check("flow_delivered_count", 64'(delivered - d_before), 64'd6);

        // Mid-stream reset: outputs drop at once and nothing stale follows.
        send(32'h41200000, 2'b00);
        send(32'h41300000, 2'b00);
        send(32'h41400000, 2'b00);
        s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_m_valid", 64'(m_valid_v), 64'd0);
        check("midrst_m_data", data_v[0], 64'd0);
        repeat (2) @(negedge aclk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge aclk);
            check($sformatf("postrst_no_output_c%0d", c), 64'(m_valid_v), 64'd0);
        end
        lit("postrst_7_s8", 2, 32'h40E00000, 2'b00, 64'd7, 1'b0, 1'b0, 1'b0);
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
